hazard_control_unit: RTL

- Generates the pipeline control consumed by the 5-stage datapath: PC_stall, IF_ID_stall, IF_flush, plus ID/EX bubble and back-end freeze.
- Registered FSM sequences D-cache waits, HLT drain and halt.
- Combinational priority logic resolves per-cycle hazards: load-use, flag, I-miss, mispredict.
- Exports a hazard code and saturating stall/flush counters for the pipeline trace/debug messages.

---
 rtl/hazard_control_unit_pkg.sv | 12 +
 rtl/hazard_control_unit_if.sv | 21 ++
 rtl/hazard_control_unit_sat_counter.sv | 15 +
 rtl/hazard_control_unit.sv | 84 ++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// cpu_ctrl_pkg: shared types and helpers for the pipeline hazard control unit
package cpu_ctrl_pkg;
   typedef enum logic [2:0] {
      HZ_NONE, HZ_DMISS, HZ_HALT, HZ_LOAD_USE, HZ_FLAG, HZ_IMISS, HZ_MISPRED
   } hazard_code_t;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} hz_state_t;
   localparam logic [3:0] REG_ZERO = 4'h0;
   // r0 is hardwired, so a load targeting it never creates a dependency
   function automatic logic src_hit(input logic en, input logic [3:0] src, input logic [3:0] rd);
      return en && src == rd && rd != REG_ZERO;
   endfunction
endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-to-hazard-unit signal bundle
interface hazard_control_unit_if import cpu_ctrl_pkg::*; #(parameter int CNT_W = 16);
   logic [3:0] ID_src1, ID_src2, EX_rd;
   logic ID_src1_en, ID_src2_en, ID_is_branch, ID_reads_flags, ID_mispredict, ID_halt;
   logic EX_MemRead, EX_RegWrite, EX_sets_flags, icache_busy, dcache_busy;
   logic PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted, stall_timeout;
   hazard_code_t hazard_code;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   modport master (
      output ID_src1, ID_src2, EX_rd, ID_src1_en, ID_src2_en, ID_is_branch, ID_reads_flags,
             ID_mispredict, ID_halt, EX_MemRead, EX_RegWrite, EX_sets_flags, icache_busy, dcache_busy,
      input  PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted, stall_timeout,
             hazard_code, stall_cycles, flush_count
   );
   modport slave (
      input  ID_src1, ID_src2, EX_rd, ID_src1_en, ID_src2_en, ID_is_branch, ID_reads_flags,
             ID_mispredict, ID_halt, EX_MemRead, EX_RegWrite, EX_sets_flags, icache_busy, dcache_busy,
      output PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted, stall_timeout,
             hazard_code, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;
   assign cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   assign cnt = cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush/freeze generation for the 5-stage pipeline,
// with HLT drain sequencing, D-miss watchdog and debug counters.
module hazard_control_unit import cpu_ctrl_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DRAIN_CYCLES   = 3,
   parameter int CNT_W          = 16
) (
   input logic clk,
   input logic rst_n,
   hazard_control_unit_if.slave hz
);
   localparam int DW = $clog2(DRAIN_CYCLES) + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   hz_state_t state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   logic timeout_q, timeout_d, load_use, flag_hz, flush_inc;
   logic [WW-1:0] wait_cnt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   assign load_use = hz.EX_MemRead && hz.EX_RegWrite &&
                     (src_hit(hz.ID_src1_en, hz.ID_src1, hz.EX_rd) || src_hit(hz.ID_src2_en, hz.ID_src2, hz.EX_rd));
   assign flag_hz = hz.ID_is_branch && hz.ID_reads_flags && hz.EX_sets_flags;
   assign timeout_d = timeout_q || (hz.dcache_busy && wait_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign hz.stall_timeout = timeout_q;
   assign hz.stall_cycles = stall_cnt;
   assign hz.flush_count = flush_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= RUN;
         drain_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         timeout_q <= timeout_d;
      end
   always_comb begin
      {hz.PC_stall, hz.IF_ID_stall, hz.IF_flush, hz.ID_flush, hz.pipe_freeze, hz.halted} = '0;
      hz.hazard_code = HZ_NONE;
      state_d = state_q;
      drain_d = drain_q;
      flush_inc = 1'b0;
      if (!rst_n) state_d = RUN;
      else if (state_q == HALTED) begin
         {hz.halted, hz.PC_stall, hz.IF_ID_stall, hz.IF_flush} = '1;
         hz.hazard_code = HZ_HALT;
      end else if (hz.dcache_busy) begin
         {hz.PC_stall, hz.IF_ID_stall, hz.pipe_freeze} = '1;
         hz.hazard_code = HZ_DMISS;
      end else if (state_q == DRAIN) begin
         {hz.PC_stall, hz.IF_flush} = '1;
         hz.hazard_code = HZ_HALT;
         if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = HALTED;
         else drain_d = drain_q + 1'b1;
      end else if (hz.ID_halt) begin
         {hz.PC_stall, hz.IF_flush} = '1;
         hz.hazard_code = HZ_HALT;
         state_d = DRAIN;
         drain_d = '0;
      end else if (load_use || flag_hz) begin
         {hz.PC_stall, hz.IF_ID_stall, hz.ID_flush} = '1;
         hz.hazard_code = load_use ? HZ_LOAD_USE : HZ_FLAG;
      end else if (hz.icache_busy) begin
         // a resolved mispredict parks in ID until the fetch miss returns
         hz.PC_stall = 1'b1;
         hz.IF_ID_stall = hz.ID_mispredict;
         hz.ID_flush = hz.ID_mispredict;
         hz.IF_flush = !hz.ID_mispredict;
         hz.hazard_code = HZ_IMISS;
      end else if (hz.ID_mispredict) begin
         hz.IF_flush = 1'b1;
         hz.hazard_code = HZ_MISPRED;
         flush_inc = 1'b1;
      end
   end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst_n(rst_n), .inc(hz.PC_stall && state_q != HALTED), .clr(1'b0), .cnt(stall_cnt)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst_n(rst_n), .inc(flush_inc), .clr(1'b0), .cnt(flush_cnt)
   );
   sat_counter #(.W(WW)) u_wait_cnt (
      .clk(clk), .rst_n(rst_n), .inc(hz.dcache_busy), .clr(!hz.dcache_busy), .cnt(wait_cnt)
   );
endmodule
